// File: rtl/gm64_pkg.sv
// Shared types for the PSRAM self-test: status colours, pattern modes, sequencer states.
package gm64_pkg;

    typedef enum logic [3:0] {
        COLOR_BLACK  = 4'd0,
        COLOR_YELLOW = 4'd1,
        COLOR_BLUE   = 4'd2,
        COLOR_GREEN  = 4'd3,
        COLOR_RED    = 4'd4
    } color_e;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_ADDR  = 2'd1,
        MODE_NADDR = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_CHECK,
        ST_PASS,
        ST_FAIL
    } state_e;

    localparam int FIXED_PATTERN = 20;

endpackage

// File: rtl/mem_pattern_gen.sv
// Test-pattern source: fixed, address, inverted address or a Galois LFSR that
// steps on advance and returns to the seed on reload (reload wins).
module mem_pattern_gen
    import gm64_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(8'hA5),
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(8'hB8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  mode_e                 mode,
    input  logic [DATA_WIDTH-1:0] addr_lsb,
    input  logic                  advance,
    input  logic                  reload,
    output logic [DATA_WIDTH-1:0] pattern
);

    logic [DATA_WIDTH-1:0] lfsr_reg;
    logic [DATA_WIDTH-1:0] lfsr_next;

    // Right-shifting Galois form: bit 0 feeds back into every tapped position.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_lfsr
            assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & LFSR_TAPS[gi]);
        end
    endgenerate
    assign lfsr_next[DATA_WIDTH-1] = lfsr_reg[0] & LFSR_TAPS[DATA_WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset || reload) begin
            lfsr_reg <= LFSR_SEED;
        end else if (advance) begin
            lfsr_reg <= lfsr_next;
        end
    end

    always_comb begin
        pattern = DATA_WIDTH'(FIXED_PATTERN);
        case (mode)
            MODE_FIXED: pattern = DATA_WIDTH'(FIXED_PATTERN);
            MODE_ADDR:  pattern = addr_lsb;
            MODE_NADDR: pattern = ~addr_lsb;
            MODE_LFSR:  pattern = lfsr_reg;
            default:    pattern = DATA_WIDTH'(FIXED_PATTERN);
        endcase
    end

endmodule

// File: rtl/mem_selftest.sv
// PSRAM range self-test: full write pass then read/compare pass over [start,end].
// Define MEM_SELFTEST_TIMEOUT_EN to bound every access wait by TIMEOUT_CYCLES.
module mem_selftest
    import gm64_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    BANK_WIDTH     = 6,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED      = DATA_WIDTH'(8'hA5),
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS      = DATA_WIDTH'(8'hB8),
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [1:0]            i_mode,
    input  logic [BANK_WIDTH-1:0] i_bank,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_end_addr,
    output logic                  o_ce,
    output logic                  o_write,
    output logic [BANK_WIDTH-1:0] o_bank,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_busy,
    input  logic                  i_dataReady,
    input  logic [DATA_WIDTH-1:0] i_dataRead,
    output logic                  o_running,
    output logic                  o_done,
    output logic                  o_fail,
    output logic                  o_timeout,
    output logic [ADDR_WIDTH-1:0] o_fail_addr,
    output logic [DATA_WIDTH-1:0] o_expected,
    output logic [DATA_WIDTH-1:0] o_actual,
    output logic [3:0]            o_status
);

    state_e                state_reg;
    mode_e                 mode_reg;
    color_e                status_reg;
    logic [BANK_WIDTH-1:0] bank_reg;
    logic [ADDR_WIDTH-1:0] addr_reg, start_reg, end_reg;
    logic [DATA_WIDTH-1:0] data_reg, rd_data_reg;
    logic [ADDR_WIDTH-1:0] fail_addr_reg;
    logic [DATA_WIDTH-1:0] expected_reg, actual_reg;
    logic                  ce_reg, write_reg, first_reg;
    logic                  running_reg, done_reg, fail_reg, timeout_reg;

    logic                  idle_like, start_accept, end_hit, wr_done, match;
    logic                  pat_advance, pat_reload, timeout_hit;
    logic [DATA_WIDTH-1:0] pattern;

    assign idle_like    = (state_reg == ST_IDLE) || (state_reg == ST_PASS) || (state_reg == ST_FAIL);
    assign start_accept = i_start && idle_like;
    assign end_hit      = (addr_reg == end_reg);
    // memCtrl raises busy a cycle after CE, so busy is meaningless while CE is still high.
    assign wr_done      = (state_reg == ST_WR_WAIT) && !first_reg && !i_busy;
    assign match        = (rd_data_reg == pattern);

    always_comb begin
        pat_reload  = 1'b0;
        pat_advance = 1'b0;
        if (start_accept || (wr_done && end_hit && !timeout_hit)) begin
            pat_reload = 1'b1;
        end else if ((wr_done && !timeout_hit) || (state_reg == ST_CHECK && match)) begin
            pat_advance = !end_hit;
        end
    end

    mem_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_SEED  (LFSR_SEED),
        .LFSR_TAPS  (LFSR_TAPS)
    ) u_pattern (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode_reg),
        .addr_lsb (DATA_WIDTH'(addr_reg)),
        .advance  (pat_advance),
        .reload   (pat_reload),
        .pattern  (pattern)
    );

`ifdef MEM_SELFTEST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             in_wait;

    assign in_wait     = (state_reg == ST_WR_ISSUE) || (state_reg == ST_WR_WAIT) ||
                         (state_reg == ST_RD_ISSUE) || (state_reg == ST_RD_WAIT);
    assign timeout_hit = in_wait && (wait_cnt_reg >= CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            wait_cnt_reg <= '0;
        end else if (((state_reg == ST_WR_ISSUE || state_reg == ST_RD_ISSUE) && !i_busy) ||
                     wr_done || (state_reg == ST_RD_WAIT && i_dataReady)) begin
            wait_cnt_reg <= '0;
        end else if (in_wait && !timeout_hit) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= MODE_FIXED;
            status_reg    <= COLOR_BLACK;
            bank_reg      <= '0;
            addr_reg      <= '0;
            start_reg     <= '0;
            end_reg       <= '0;
            data_reg      <= '0;
            rd_data_reg   <= '0;
            fail_addr_reg <= '0;
            expected_reg  <= '0;
            actual_reg    <= '0;
            ce_reg        <= 1'b0;
            write_reg     <= 1'b0;
            first_reg     <= 1'b0;
            running_reg   <= 1'b0;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            ce_reg <= 1'b0;
            if (timeout_hit) begin
                state_reg     <= ST_FAIL;
                status_reg    <= COLOR_RED;
                fail_addr_reg <= addr_reg;
                expected_reg  <= pattern;
                actual_reg    <= '0;
                running_reg   <= 1'b0;
                done_reg      <= 1'b1;
                fail_reg      <= 1'b1;
                timeout_reg   <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_PASS, ST_FAIL: begin
                        if (i_start) begin
                            mode_reg     <= mode_e'(i_mode);
                            bank_reg     <= i_bank;
                            start_reg    <= i_start_addr;
                            end_reg      <= i_end_addr;
                            addr_reg     <= i_start_addr;
                            expected_reg <= '0;
                            actual_reg   <= '0;
                            timeout_reg  <= 1'b0;
                            if (i_start_addr > i_end_addr) begin
                                state_reg     <= ST_FAIL;
                                status_reg    <= COLOR_RED;
                                fail_addr_reg <= i_start_addr;
                                running_reg   <= 1'b0;
                                done_reg      <= 1'b1;
                                fail_reg      <= 1'b1;
                            end else begin
                                state_reg     <= ST_WR_ISSUE;
                                status_reg    <= COLOR_YELLOW;
                                fail_addr_reg <= '0;
                                running_reg   <= 1'b1;
                                done_reg      <= 1'b0;
                                fail_reg      <= 1'b0;
                            end
                        end
                    end
                    ST_WR_ISSUE: begin
                        if (!i_busy) begin
                            ce_reg    <= 1'b1;
                            write_reg <= 1'b1;
                            data_reg  <= pattern;
                            first_reg <= 1'b1;
                            state_reg <= ST_WR_WAIT;
                        end
                    end
                    ST_WR_WAIT: begin
                        first_reg <= 1'b0;
                        if (wr_done) begin
                            if (end_hit) begin
                                addr_reg   <= start_reg;
                                status_reg <= COLOR_BLUE;
                                state_reg  <= ST_RD_ISSUE;
                            end else begin
                                addr_reg  <= addr_reg + ADDR_WIDTH'(1);
                                state_reg <= ST_WR_ISSUE;
                            end
                        end
                    end
                    ST_RD_ISSUE: begin
                        if (!i_busy) begin
                            ce_reg    <= 1'b1;
                            write_reg <= 1'b0;
                            state_reg <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (i_dataReady) begin
                            rd_data_reg <= i_dataRead;
                            state_reg   <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (!match) begin
                            state_reg     <= ST_FAIL;
                            status_reg    <= COLOR_RED;
                            fail_addr_reg <= addr_reg;
                            expected_reg  <= pattern;
                            actual_reg    <= rd_data_reg;
                            running_reg   <= 1'b0;
                            done_reg      <= 1'b1;
                            fail_reg      <= 1'b1;
                        end else if (end_hit) begin
                            state_reg   <= ST_PASS;
                            status_reg  <= COLOR_GREEN;
                            running_reg <= 1'b0;
                            done_reg    <= 1'b1;
                        end else begin
                            addr_reg  <= addr_reg + ADDR_WIDTH'(1);
                            state_reg <= ST_RD_ISSUE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_ce        = ce_reg;
    assign o_write     = write_reg;
    assign o_bank      = bank_reg;
    assign o_addr      = addr_reg;
    assign o_data      = data_reg;
    assign o_running   = running_reg;
    assign o_done      = done_reg;
    assign o_fail      = fail_reg;
    assign o_timeout   = timeout_reg;
    assign o_fail_addr = fail_addr_reg;
    assign o_expected  = expected_reg;
    assign o_actual    = actual_reg;
    assign o_status    = status_reg;

endmodule

// File: tb/tb_mem_selftest.sv
// Directed bench for mem_selftest against a small behavioural memCtrl model.
module tb_mem_selftest;
    import gm64_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [5:0]  i_bank = 6'd0;
    logic [15:0] i_start_addr = 16'd0;
    logic [15:0] i_end_addr = 16'd0;
    logic        o_ce, o_write;
    logic [5:0]  o_bank;
    logic [15:0] o_addr;
    logic [7:0]  o_data;
    logic        i_busy;
    logic        i_dataReady;
    logic [7:0]  i_dataRead;
    logic        o_running, o_done, o_fail, o_timeout;
    logic [15:0] o_fail_addr;
    logic [7:0]  o_expected, o_actual;
    logic [3:0]  o_status;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_selftest #(
`ifdef MEM_SELFTEST_TIMEOUT_EN
        .TIMEOUT_CYCLES (16)
`else
        .TIMEOUT_CYCLES (1024)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_bank       (i_bank),
        .i_start_addr (i_start_addr),
        .i_end_addr   (i_end_addr),
        .o_ce         (o_ce),
        .o_write      (o_write),
        .o_bank       (o_bank),
        .o_addr       (o_addr),
        .o_data       (o_data),
        .i_busy       (i_busy),
        .i_dataReady  (i_dataReady),
        .i_dataRead   (i_dataRead),
        .o_running    (o_running),
        .o_done       (o_done),
        .o_fail       (o_fail),
        .o_timeout    (o_timeout),
        .o_fail_addr  (o_fail_addr),
        .o_expected   (o_expected),
        .o_actual     (o_actual),
        .o_status     (o_status)
    );

    // memCtrl model: busy for 3 cycles after CE, dataReady pulses as busy drops.
    logic [7:0]  mem [0:65535];
    logic [15:0] pend_addr;
    logic        pend_rd;
    int          lat;
    int          ce_count = 0;
    logic [15:0] last_wr_addr;
    logic [7:0]  last_wr_data;
    logic        corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = 16'd0;
    logic        no_ready = 1'b0;

    always @(posedge clk) begin
        i_dataReady <= 1'b0;
        if (reset) begin
            i_busy     <= 1'b0;
            i_dataRead <= 8'd0;
            pend_rd    <= 1'b0;
            pend_addr  <= 16'd0;
            lat        <= 0;
        end else if (o_ce) begin
            ce_count  <= ce_count + 1;
            i_busy    <= 1'b1;
            lat       <= 2;
            pend_rd   <= !o_write;
            pend_addr <= o_addr;
            if (o_write) begin
                mem[o_addr]  <= o_data;
                last_wr_addr <= o_addr;
                last_wr_data <= o_data;
            end
        end else if (lat > 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                i_busy <= 1'b0;
                if (pend_rd && !no_ready) begin
                    i_dataReady <= 1'b1;
                    i_dataRead  <= (corrupt_en && pend_addr == corrupt_addr) ? 8'h00 : mem[pend_addr];
                end
                pend_rd <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", tag, actual, expected);
        end
    endtask

    task automatic start_test(input logic [1:0] mode, input logic [15:0] sa, input logic [15:0] ea);
        @(negedge clk);
        i_mode = mode;
        i_bank = 6'h2A;
        i_start_addr = sa;
        i_end_addr = ea;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, o_done}, 32'd1);
    endtask

    int ce_base;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
        mem[0] = 8'h5A;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_status", {28'd0, o_status}, {28'd0, COLOR_BLACK});
        check_eq("rst_ce", {31'd0, o_ce}, 32'd0);
        check_eq("rst_done", {31'd0, o_done}, 32'd0);
        check_eq("rst_running", {31'd0, o_running}, 32'd0);
        check_eq("rst_data", {24'd0, o_data}, 32'd0);
        $display("txn reset: status=%0d ce=%0b done=%0b", o_status, o_ce, o_done);

        // Mode 0, ideal memory.
        ce_base = ce_count;
        start_test(2'd0, 16'hC000, 16'hC003);
        check_eq("m0_running", {31'd0, o_running}, 32'd1);
        check_eq("m0_bank", {26'd0, o_bank}, 32'h2A);
        wait_done("m0_done", 500);
        check_eq("m0_fail", {31'd0, o_fail}, 32'd0);
        check_eq("m0_status", {28'd0, o_status}, {28'd0, COLOR_GREEN});
        check_eq("m0_ce", ce_count - ce_base, 32'd8);
        check_eq("m0_mem", {24'd0, mem[16'hC002]}, 32'd20);
        $display("txn mode0 C000..C003: done=%0b fail_flag=%0b ce=%0d", o_done, o_fail, ce_count - ce_base);

        // Mode 1 with a corrupted read at C002.
        corrupt_en = 1'b1;
        corrupt_addr = 16'hC002;
        ce_base = ce_count;
        start_test(2'd1, 16'hC000, 16'hC003);
        wait_done("m1_done", 500);
        check_eq("m1_fail", {31'd0, o_fail}, 32'd1);
        check_eq("m1_fail_addr", {16'd0, o_fail_addr}, 32'hC002);
        check_eq("m1_expected", {24'd0, o_expected}, 32'h02);
        check_eq("m1_actual", {24'd0, o_actual}, 32'h00);
        check_eq("m1_status", {28'd0, o_status}, {28'd0, COLOR_RED});
        repeat (10) @(negedge clk);
        check_eq("m1_ce_after", ce_count - ce_base, 32'd7);
        $display("txn mode1 corrupt C002: fail_addr=%h exp=%h act=%h", o_fail_addr, o_expected, o_actual);
        corrupt_en = 1'b0;

        // Top-of-range, mode 2.
        ce_base = ce_count;
        start_test(2'd2, 16'hFFFE, 16'hFFFF);
        wait_done("m2_done", 500);
        check_eq("m2_fail", {31'd0, o_fail}, 32'd0);
        check_eq("m2_last_addr", {16'd0, last_wr_addr}, 32'hFFFF);
        check_eq("m2_last_data", {24'd0, last_wr_data}, 32'h00);
        check_eq("m2_ce", ce_count - ce_base, 32'd4);
        $display("txn mode2 FFFE..FFFF: fail_flag=%0b last_wr=%h@%h", o_fail, last_wr_data, last_wr_addr);

        // Empty range.
        ce_base = ce_count;
        start_test(2'd0, 16'h0010, 16'h000F);
        check_eq("inv_done", {31'd0, o_done}, 32'd1);
        check_eq("inv_fail", {31'd0, o_fail}, 32'd1);
        check_eq("inv_fail_addr", {16'd0, o_fail_addr}, 32'h0010);
        check_eq("inv_exp_act", {16'd0, o_expected, o_actual}, 32'd0);
        check_eq("inv_ce", ce_count - ce_base, 32'd0);
        $display("txn start>end: fail_flag=%0b fail_addr=%h", o_fail, o_fail_addr);

        // Reset in RD_WAIT, then an LFSR run with an ignored mid-test start.
        begin
            int  n = 0;
            bit  seen = 1'b0;
            start_test(2'd3, 16'hC000, 16'hC003);
            while (!seen && n < 500) begin
                @(negedge clk);
                n++;
                if (o_ce && !o_write) seen = 1'b1;
            end
            check_eq("rst_rd_seen", {31'd0, seen}, 32'd1);
            reset = 1'b1;
            @(negedge clk);
            check_eq("midrst_ce", {31'd0, o_ce}, 32'd0);
            check_eq("midrst_outs", {o_status, o_running, o_done, o_fail, o_addr}, 32'd0);
            reset = 1'b0;
            $display("txn reset in RD_WAIT: ce=%0b status=%0d", o_ce, o_status);
        end
        @(negedge clk);
        ce_base = ce_count;
        start_test(2'd3, 16'hC000, 16'hC007);
        repeat (5) @(negedge clk);
        start_test(2'd0, 16'h0000, 16'h0000);
        wait_done("lfsr_done", 1000);
        check_eq("lfsr_fail", {31'd0, o_fail}, 32'd0);
        check_eq("lfsr_status", {28'd0, o_status}, {28'd0, COLOR_GREEN});
        check_eq("lfsr_ce", ce_count - ce_base, 32'd16);
        check_eq("lfsr_w0", {24'd0, mem[16'hC000]}, 32'hA5);
        check_eq("lfsr_w1", {24'd0, mem[16'hC001]}, 32'hEA);
        check_eq("lfsr_w2", {24'd0, mem[16'hC002]}, 32'h75);
        check_eq("ignored_start", {24'd0, mem[16'h0000]}, 32'h5A);
        $display("txn lfsr C000..C007: fail_flag=%0b ce=%0d", o_fail, ce_count - ce_base);

`ifdef MEM_SELFTEST_TIMEOUT_EN
        no_ready = 1'b1;
        start_test(2'd0, 16'hC000, 16'hC000);
        wait_done("to_done", 200);
        check_eq("to_fail", {31'd0, o_fail}, 32'd1);
        check_eq("to_timeout", {31'd0, o_timeout}, 32'd1);
        check_eq("to_fail_addr", {16'd0, o_fail_addr}, 32'hC000);
        check_eq("to_actual", {24'd0, o_actual}, 32'd0);
        $display("txn timeout: timeout=%0b fail_addr=%h", o_timeout, o_fail_addr);
        no_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_selftest.md
Name: mem_selftest

Overview:
Parametrised PSRAM self-test sequencer sitting between the top level and memCtrl. It replaces the hand-coded write-20/read-back check with a configurable range test. It runs a full write pass over [start,end] and then a read/compare pass, and reports on the status colour (Color enum) and on result registers. It drives memCtrl's CE/write/bank/addr/data handshake directly.

Parameters:
ADDR_WIDTH, 16, address bus width
BANK_WIDTH, 6, bank select width
DATA_WIDTH, 8, data word width
LFSR_SEED, 8'hA5, LFSR seed for mode 3 (truncated/zero-extended to DATA_WIDTH; must be nonzero)
LFSR_TAPS, 8'hB8, Galois feedback mask for mode 3
TIMEOUT_CYCLES, 1024, wait limit per access (only with MEM_SELFTEST_TIMEOUT_EN)

Ports:
clk  in  1  system clock (clkRAM domain)
reset  in  1  synchronous, active-high
i_start  in  1  one-cycle start pulse
i_mode  in  2  0 fixed 8'd20, 1 addr[DW-1:0], 2 ~addr[DW-1:0], 3 LFSR
i_bank  in  BANK_WIDTH  bank under test, sampled at start
i_start_addr  in  ADDR_WIDTH  first address, sampled at start
i_end_addr  in  ADDR_WIDTH  last address, inclusive, sampled at start
o_ce  out  1  memCtrl CE, one-cycle pulse per access
o_write  out  1  1 write / 0 read, valid with o_ce
o_bank  out  BANK_WIDTH  to memCtrl
o_addr  out  ADDR_WIDTH  to memCtrl
o_data  out  DATA_WIDTH  write data to memCtrl
i_busy  in  1  memCtrl busy
i_dataReady  in  1  read data valid pulse
i_dataRead  in  DATA_WIDTH  read data
o_running  out  1  test in progress
o_done  out  1  level, set on PASS/FAIL until next start or reset
o_fail  out  1  level, valid when o_done
o_timeout  out  1  fail cause was timeout
o_fail_addr  out  ADDR_WIDTH  first failing address
o_expected  out  DATA_WIDTH  expected data at fail
o_actual  out  DATA_WIDTH  read data at fail
o_status  out  4  Color: black idle, yellow write pass, blue read pass, green PASS, red FAIL

Behaviour:
- Reset: every output is 0 (o_status = black), state IDLE. Reset mid-access deasserts o_ce on the same edge. Any outstanding memCtrl transaction is abandoned.
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CHECK, PASS, FAIL.
- i_start is accepted in IDLE/PASS/FAIL only and ignored while running. On start: latch bank/range/mode, clear o_done/o_fail/o_timeout/result regs, addr := start, reload LFSR.
- If start > end: go to FAIL on the next cycle with fail_addr = start and expected = actual = 0.
- WR_ISSUE: waits for i_busy = 0, then pulses o_ce = 1 with o_write = 1 for exactly one cycle. o_addr and o_data hold stable from issue until the wait completes.
- WR_WAIT: i_busy is ignored in the first cycle after issue (memCtrl raises busy one cycle after CE). After that, i_busy = 0 completes the access.
  - If addr == end, go to RD_ISSUE with addr := start and the LFSR reloaded.
  - Otherwise addr++ and the pattern advances, then back to WR_ISSUE.
- RD_ISSUE: same as WR_ISSUE with o_write = 0. RD_WAIT leaves on i_dataReady = 1, latching i_dataRead.
- CHECK (1 cycle): compare latched data against the regenerated pattern.
  - Mismatch: FAIL, recording addr/expected/actual.
  - Match with addr == end: PASS.
  - Otherwise addr++, back to RD_ISSUE.
- The end comparison happens before the increment, so end = 2^ADDR_WIDTH-1 never wraps. start == end is a single-word test.
- LFSR (mode 3): advances once per completed access in each pass, so both passes regenerate an identical sequence.
- The i_dataReady pulse must be at least 1 clk wide. A pulse seen outside RD_WAIT is ignored.
- o_running = 1 in all states except IDLE/PASS/FAIL.
- Minimum latency per word is issue + 2 cycles for writes and issue + wait + 1 CHECK cycle for reads.

Optional Feature:
MEM_SELFTEST_TIMEOUT_EN:
- Defined: a wait counter clears on each issue. If WR_WAIT/RD_WAIT (or ISSUE blocked by busy) exceeds TIMEOUT_CYCLES cycles, go to FAIL with o_timeout = 1, fail_addr = current addr, and actual = 0.
- Not defined: no counter; waits are unbounded and o_timeout is tied to 0.

Decomposition:
- Shared package gm64_pkg holds: the Color enum (moved out of the top level), the mode enum (MODE_FIXED, MODE_ADDR, MODE_NADDR, MODE_LFSR), the state enum, and the FIXED_PATTERN = 20 constant.
- One sub-module, mem_pattern_gen: mode + addr + advance/reload inputs produce a DATA_WIDTH pattern. It contains the LFSR and is instantiated once.

Test Plan:
- Mode 0, range C000..C003, ideal memory model: 4 writes of 20, then 4 reads. Expect PASS, status green, exactly 8 CE pulses, o_done = 1.
- Mode 1, model corrupts the read at C002 (returns 00): expect FAIL, fail_addr = C002, expected = 02, actual = 00, status red, and no CE after the CHECK.
- Range FFFE..FFFF, mode 2: expect PASS with no wrap, and the last write data = 00 at FFFF.
- start = 0010 > end = 000F: expect FAIL within 2 cycles, zero CE pulses.
- Reset asserted during RD_WAIT: o_ce = 0 and outputs = 0 the next cycle. A new i_start then runs to PASS; an i_start issued mid-test is ignored.
- With MEM_SELFTEST_TIMEOUT_EN and TIMEOUT_CYCLES = 16, model never returns dataReady: expect FAIL with o_timeout = 1 about 17 cycles after the read issue.
